// File: rtl/ita_rf_reader_pkg.sv
// Shared types and constants for the register-file stream reader and its output FIFO.
package ita_rf_reader_pkg;

   localparam int unsigned FIFO_DEPTH       = 2;
   localparam int unsigned FIFO_CNT_WIDTH   = $clog2(FIFO_DEPTH + 1);
   localparam int unsigned ENTRY_DATA_WIDTH = 32;

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      DRAIN
   } state_t;

   typedef struct packed {
      logic [ENTRY_DATA_WIDTH-1:0] data;
      logic                        last;
   } fifo_entry_t;

endpackage

// File: rtl/ita_rf_reader_fifo2.sv
// Two-entry registered FIFO; the head entry is presented directly from storage registers.
module ita_rf_reader_fifo2
   import ita_rf_reader_pkg::*;
(
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      push,
   input  fifo_entry_t               push_entry,
   input  logic                      pop,
   output fifo_entry_t               head,
   output logic [FIFO_CNT_WIDTH-1:0] count
);

   fifo_entry_t mem [FIFO_DEPTH];
   logic        wr_ptr;
   logic        rd_ptr;
   logic        do_push;
   logic        do_pop;

   // A push into a full FIFO is legal when the head leaves on the same edge.
   always_comb begin
      do_pop  = pop && (count != '0);
      do_push = push && ((count != FIFO_CNT_WIDTH'(FIFO_DEPTH)) || do_pop);
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         mem    <= '{default: '0};
         wr_ptr <= 1'b0;
         rd_ptr <= 1'b0;
         count  <= '0;
      end else begin
         if (do_push) begin
            mem[wr_ptr] <= push_entry;
            wr_ptr      <= ~wr_ptr;
         end
         if (do_pop) begin
            rd_ptr <= ~rd_ptr;
         end
         case ({do_push, do_pop})
            2'b10:   count <= count + FIFO_CNT_WIDTH'(1);
            2'b01:   count <= count - FIFO_CNT_WIDTH'(1);
            default: count <= count;
         endcase
      end
   end

   assign head = mem[rd_ptr];

endmodule

// File: rtl/ita_rf_stream_reader.sv
// Burst read master for one register-file read port, streaming words on valid/ready.
// Optional address stride input enabled by ITA_RF_READER_STRIDE_EN.
module ita_rf_stream_reader
   import ita_rf_reader_pkg::*;
#(
   parameter int unsigned ADDR_WIDTH = 5,
   parameter int unsigned DATA_WIDTH = ENTRY_DATA_WIDTH,
   parameter int unsigned LEN_WIDTH  = 5
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  cmd_valid_i,
   output logic                  cmd_ready_o,
   input  logic [ADDR_WIDTH-1:0] cmd_addr_i,
   input  logic [LEN_WIDTH-1:0]  cmd_len_i,
`ifdef ITA_RF_READER_STRIDE_EN
   input  logic [ADDR_WIDTH-1:0] cmd_stride_i,
`endif
   output logic                  rf_re_o,
   output logic [ADDR_WIDTH-1:0] rf_raddr_o,
   input  logic [DATA_WIDTH-1:0] rf_rdata_i,
   output logic                  out_valid_o,
   input  logic                  out_ready_i,
   output logic [DATA_WIDTH-1:0] out_data_o,
   output logic                  out_last_o,
   output logic                  busy_o
);

   localparam int unsigned CW = FIFO_CNT_WIDTH + 1;

   state_t                    state;
   logic [ADDR_WIDTH-1:0]     cur_addr;
   logic [ADDR_WIDTH-1:0]     step;
   logic [LEN_WIDTH-1:0]      remaining;
   logic                      inflight;
   logic                      inflight_last;
   logic [FIFO_CNT_WIDTH-1:0] fifo_count;
   logic [CW-1:0]             credit;
   logic                      pop;
   logic                      issue;
   fifo_entry_t               push_entry;
   fifo_entry_t               head;

`ifdef ITA_RF_READER_STRIDE_EN
   logic [ADDR_WIDTH-1:0] stride;
   assign step = stride;
`else
   assign step = ADDR_WIDTH'(1);
`endif

   // Occupancy after this edge must stay within the FIFO, counting the word still in flight.
   always_comb begin
      pop    = out_valid_o && out_ready_i;
      credit = CW'(fifo_count) + CW'(inflight) - CW'(pop);
      issue  = (state == RUN) && (credit < CW'(FIFO_DEPTH));
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state         <= IDLE;
         cur_addr      <= '0;
         remaining     <= '0;
         inflight      <= 1'b0;
         inflight_last <= 1'b0;
`ifdef ITA_RF_READER_STRIDE_EN
         stride        <= ADDR_WIDTH'(1);
`endif
      end else begin
         inflight      <= issue;
         inflight_last <= issue && (remaining == '0);
         case (state)
            IDLE: begin
               if (cmd_valid_i) begin
                  cur_addr  <= cmd_addr_i;
                  remaining <= cmd_len_i;
`ifdef ITA_RF_READER_STRIDE_EN
                  stride    <= cmd_stride_i;
`endif
                  state     <= RUN;
               end
            end
            RUN: begin
               if (issue) begin
                  cur_addr  <= cur_addr + step;
                  remaining <= remaining - LEN_WIDTH'(1);
                  if (remaining == '0) begin
                     state <= DRAIN;
                  end
               end
            end
            DRAIN: begin
               if (pop && out_last_o) begin
                  state <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   // Read data arrives one cycle after issue; it is pushed unconditionally since credit reserved a slot.
   always_comb begin
      push_entry      = '0;
      push_entry.data = ENTRY_DATA_WIDTH'(rf_rdata_i);
      push_entry.last = inflight_last;
   end

   ita_rf_reader_fifo2 u_fifo (
      .clk        (clk),
      .rst_n      (rst_n),
      .push       (inflight),
      .push_entry (push_entry),
      .pop        (pop),
      .head       (head),
      .count      (fifo_count)
   );

   assign cmd_ready_o = (state == IDLE);
   assign busy_o      = (state != IDLE);
   assign rf_re_o     = issue;
   assign rf_raddr_o  = cur_addr;
   assign out_valid_o = (fifo_count != '0);
   assign out_data_o  = DATA_WIDTH'(head.data);
   assign out_last_o  = head.last;

endmodule

// File: tb/tb_ita_rf_stream_reader.sv
// Scoreboard bench for ita_rf_stream_reader with a registered-address register-file model.
module tb_ita_rf_stream_reader;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        cmd_valid_i;
   logic        cmd_ready_o;
   logic [4:0]  cmd_addr_i;
   logic [4:0]  cmd_len_i;
`ifdef ITA_RF_READER_STRIDE_EN
   logic [4:0]  cmd_stride_i;
`endif
   logic        rf_re_o;
   logic [4:0]  rf_raddr_o;
   logic [31:0] rf_rdata_i;
   logic        out_valid_o;
   logic        out_ready_i;
   logic [31:0] out_data_o;
   logic        out_last_o;
   logic        busy_o;

   typedef struct {
      logic [31:0] data;
      logic        last;
   } exp_t;

   exp_t        exp_q[$];
   logic [4:0]  addr_q[$];
   logic [31:0] rf_mem [32];
   logic [4:0]  rf_addr_q = '0;

   int checks = 0;
   int passes = 0;

   logic        stalled = 1'b0;
   logic [31:0] hold_data;
   logic        hold_last;

   always #5 clk = ~clk;

   ita_rf_stream_reader #(
      .ADDR_WIDTH (5),
      .DATA_WIDTH (32),
      .LEN_WIDTH  (5)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .cmd_valid_i (cmd_valid_i),
      .cmd_ready_o (cmd_ready_o),
      .cmd_addr_i  (cmd_addr_i),
      .cmd_len_i   (cmd_len_i),
`ifdef ITA_RF_READER_STRIDE_EN
      .cmd_stride_i(cmd_stride_i),
`endif
      .rf_re_o     (rf_re_o),
      .rf_raddr_o  (rf_raddr_o),
      .rf_rdata_i  (rf_rdata_i),
      .out_valid_o (out_valid_o),
      .out_ready_i (out_ready_i),
      .out_data_o  (out_data_o),
      .out_last_o  (out_last_o),
      .busy_o      (busy_o)
   );

   // Register file read port: address registered on ReadEnable, data presented the next cycle.
   always @(posedge clk) if (rf_re_o) rf_addr_q <= rf_raddr_o;
   assign rf_rdata_i = rf_mem[rf_addr_q];

   function automatic void check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act === exp) passes++;
      else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
   endfunction

   function automatic logic [31:0] mem_word(input int unsigned i);
      return 32'hC0DE_0000 + 32'(i) * 32'h0000_0101;
   endfunction

   // Monitor: issued addresses, output handshakes and stall stability, sampled mid-cycle.
   always @(negedge clk) begin
      exp_t e;
      logic [4:0] a;
      if (!rst_n) begin
         stalled = 1'b0;
      end else begin
         if (rf_re_o) begin
            if (addr_q.size() == 0) check("unexpected_issue", 64'(rf_raddr_o), 64'hFFFF);
            else begin
               a = addr_q.pop_front();
               check("issue_addr", 64'(rf_raddr_o), 64'(a));
            end
         end
         if (stalled)
            check("stall_hold", {31'd0, out_valid_o, out_last_o, out_data_o},
                  {31'd0, 1'b1, hold_last, hold_data});
         if (out_valid_o && out_ready_i) begin
            if (exp_q.size() == 0) check("unexpected_word", 64'(out_data_o), 64'hFFFF_FFFF_FFFF);
            else begin
               e = exp_q.pop_front();
               check("out_data", 64'(out_data_o), 64'(e.data));
               check("out_last", 64'(out_last_o), 64'(e.last));
            end
         end
         stalled   = out_valid_o && !out_ready_i;
         hold_data = out_data_o;
         hold_last = out_last_o;
      end
   end

   task automatic send_cmd(input logic [4:0] addr, input logic [4:0] len, input logic [4:0] stride);
      exp_t e;
      logic [4:0] a;
      int n;
      a = addr;
      for (int unsigned k = 0; k <= 32'(len); k++) begin
         addr_q.push_back(a);
         e.data = mem_word(32'(a));
         e.last = (k == 32'(len));
         exp_q.push_back(e);
         a = a + stride;
      end
      cmd_valid_i = 1'b1;
      cmd_addr_i  = addr;
      cmd_len_i   = len;
`ifdef ITA_RF_READER_STRIDE_EN
      cmd_stride_i = stride;
`endif
      n = 0;
      @(negedge clk);
      while (!cmd_ready_o && n < 50) begin
         n++;
         @(negedge clk);
      end
      if (!cmd_ready_o) check("cmd_accept_timeout", 64'(cmd_ready_o), 64'd1);
      @(posedge clk);
      #1 cmd_valid_i = 1'b0;
   endtask

   task automatic wait_idle(input string name);
      int n;
      n = 0;
      while ((exp_q.size() != 0 || busy_o) && n < 200) begin
         @(negedge clk);
         n++;
      end
      check({name, "_drained"}, 64'(exp_q.size()), 64'd0);
      check({name, "_idle"}, 64'(busy_o), 64'd0);
      @(posedge clk);
      #1;
   endtask

   initial begin
      int issues;
      for (int unsigned i = 0; i < 32; i++) rf_mem[i] = mem_word(i);
      rst_n       = 1'b0;
      cmd_valid_i = 1'b0;
      cmd_addr_i  = '0;
      cmd_len_i   = '0;
`ifdef ITA_RF_READER_STRIDE_EN
      cmd_stride_i = 5'd1;
`endif
      out_ready_i = 1'b1;
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;

      @(negedge clk);
      check("rst_cmd_ready", 64'(cmd_ready_o), 64'd1);
      check("rst_outputs", {47'd0, rf_re_o, rf_raddr_o, out_valid_o, out_last_o, busy_o, 6'd0},
            64'd0);
      check("rst_data", 64'(out_data_o), 64'd0);
      @(posedge clk);
      #1;

      // Single word: data with last exactly two cycles after accept.
      send_cmd(5'd3, 5'd0, 5'd1);
      @(negedge clk);
      check("t1_busy", 64'(busy_o), 64'd1);
      check("t1_valid_c0", 64'(out_valid_o), 64'd0);
      @(negedge clk);
      check("t1_valid_c1", 64'(out_valid_o), 64'd0);
      @(negedge clk);
      check("t1_valid_c2", {31'd0, out_valid_o, out_last_o, out_data_o},
            {31'd0, 1'b1, 1'b1, mem_word(3)});
      @(negedge clk);
      check("t1_busy_fall", 64'(busy_o), 64'd0);
      @(posedge clk);
      #1;
      wait_idle("t1");

      // Eight words back-to-back.
      send_cmd(5'd0, 5'd7, 5'd1);
      repeat (2) @(negedge clk);
      for (int unsigned k = 0; k < 8; k++) begin
         @(negedge clk);
         check("t2_b2b_valid", 64'(out_valid_o), 64'd1);
      end
      @(posedge clk);
      #1;
      wait_idle("t2");

      // Address wrap 30,31,0,1.
      send_cmd(5'd30, 5'd3, 5'd1);
      wait_idle("t3");

      // Backpressure: only two reads outstanding while stalled.
      out_ready_i = 1'b0;
      send_cmd(5'd12, 5'd5, 5'd1);
      issues = 0;
      repeat (6) begin
         @(negedge clk);
         if (rf_re_o) issues++;
      end
      check("t4_stall_issues", 64'(issues), 64'd2);
      check("t4_stall_re_low", 64'(rf_re_o), 64'd0);
      check("t4_stall_valid", 64'(out_valid_o), 64'd1);
      @(posedge clk);
      #1 out_ready_i = 1'b1;
      wait_idle("t4");

      // Reset mid-burst discards the partial burst.
      send_cmd(5'd20, 5'd7, 5'd1);
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b0;
      exp_q.delete();
      addr_q.delete();
      @(posedge clk);
      #1 rst_n = 1'b1;
      @(negedge clk);
      check("t5_valid_after_rst", 64'(out_valid_o), 64'd0);
      check("t5_ready_after_rst", 64'(cmd_ready_o), 64'd1);
      check("t5_re_after_rst", 64'(rf_re_o), 64'd0);
      @(posedge clk);
      #1;
      send_cmd(5'd10, 5'd1, 5'd1);
      wait_idle("t5");

`ifdef ITA_RF_READER_STRIDE_EN
      send_cmd(5'd1, 5'd2, 5'd4);
      wait_idle("t6");
`endif

      check("addr_queue_empty", 64'(addr_q.size()), 64'd0);
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1, "watchdog");
   end

endmodule
